// File: rtl/adc_serial_rx_multi.sv
// Multi-line SPI ADC receiver: one CS frame, N_CH MSB-first lines, lead-zero/length checked; no backpressure.
// Result and ticks appear one SCLK after the CS-high edge; `ADC_AVG_EN averages 2**AVG_LOG2 valid frames.
module adc_serial_rx_multi #(
    parameter int FRAME_BITS = 16,
    parameter int DATA_BITS  = 12,
    parameter int LEAD_ZEROS = 4,
    parameter int N_CH       = 2,
    parameter int AVG_LOG2   = 2
) (
    input  logic                         SCLK,
    input  logic                         reset,
    input  logic                         CS,
    input  logic [N_CH-1:0]              SDATA,
    output logic                         rx_done_tick,
    output logic                         frame_err,
    output logic [N_CH*FRAME_BITS-1:0]   b_reg,
    output logic [N_CH*DATA_BITS-1:0]    data_Out,
    output logic [15:0]                  frame_cnt
);
    localparam int CNT_W = $clog2(FRAME_BITS + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                    state, state_nxt;
    logic [CNT_W-1:0]          bit_cnt, bit_cnt_nxt;
    logic                      shift_en, frame_end, lead_ok, frame_ok, out_load;
    logic [N_CH*DATA_BITS-1:0] sample, out_val;

    always_ff @(posedge SCLK) begin
        if (!reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_en    = 1'b0;
        frame_end   = 1'b0;
        case (state)
            IDLE: begin
                if (!CS) begin
                    state_nxt   = SHIFT;
                    bit_cnt_nxt = CNT_W'(1);
                    shift_en    = 1'b1;
                end
            end
            SHIFT: begin
                if (CS) begin
                    state_nxt   = IDLE;
                    bit_cnt_nxt = '0;
                    frame_end   = 1'b1;
                end else if (bit_cnt < CNT_W'(FRAME_BITS)) begin
                    // surplus bits beyond FRAME_BITS are dropped: register and count hold
                    shift_en    = 1'b1;
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        lead_ok = 1'b1;
        sample  = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            sample[ch*DATA_BITS +: DATA_BITS] = b_reg[ch*FRAME_BITS +: DATA_BITS];
            for (int b = FRAME_BITS - LEAD_ZEROS; b < FRAME_BITS; b++)
                if (b_reg[ch*FRAME_BITS + b]) lead_ok = 1'b0;
        end
    end

    assign frame_ok = frame_end && (bit_cnt == CNT_W'(FRAME_BITS)) && lead_ok;

`ifdef ADC_AVG_EN
    localparam int ACC_W = DATA_BITS + AVG_LOG2;

    logic [ACC_W-1:0]    acc     [N_CH];
    logic [ACC_W-1:0]    acc_sum [N_CH];
    logic [AVG_LOG2-1:0] avg_cnt;

    always_comb begin
        out_val = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            acc_sum[ch] = acc[ch] + ACC_W'(sample[ch*DATA_BITS +: DATA_BITS]);
            out_val[ch*DATA_BITS +: DATA_BITS] = acc_sum[ch][ACC_W-1:AVG_LOG2];
        end
    end

    assign out_load = frame_ok && (avg_cnt == '1);

    always_ff @(posedge SCLK) begin
        if (!reset) begin
            avg_cnt <= '0;
            for (int ch = 0; ch < N_CH; ch++) acc[ch] <= '0;
        end else if (frame_ok) begin
            avg_cnt <= avg_cnt + AVG_LOG2'(1);
            for (int ch = 0; ch < N_CH; ch++)
                acc[ch] <= (avg_cnt == '1) ? '0 : acc_sum[ch];
        end
    end
`else
    assign out_val  = sample;
    assign out_load = frame_ok;

    // AVG_LOG2 only sizes the averaging path, which is absent in this build
    if (AVG_LOG2 < 0) begin : g_avg_log2_unused
    end
`endif

    always_ff @(posedge SCLK) begin
        if (!reset) begin
            b_reg        <= '0;
            data_Out     <= '0;
            frame_cnt    <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            rx_done_tick <= out_load;
            frame_err    <= frame_end && !frame_ok;
            frame_cnt    <= frame_cnt + 16'(frame_ok);
            if (out_load) data_Out <= out_val;
            if (shift_en)
                for (int ch = 0; ch < N_CH; ch++)
                    b_reg[ch*FRAME_BITS +: FRAME_BITS] <=
                        {b_reg[ch*FRAME_BITS +: FRAME_BITS-1], SDATA[ch]};
        end
    end
endmodule

// File: tb/tb_adc_serial_rx_multi.sv
// Bench for adc_serial_rx_multi: spec vector table, reset/wrap sequences, random frames vs. a frame-level model.
module tb_adc_serial_rx_multi;
    localparam int FB = 16;
    localparam int DB = 12;
    localparam int NC = 2;
    localparam int AL = 2;

    logic              SCLK  = 1'b0;
    logic              reset = 1'b0;
    logic              CS    = 1'b1;
    logic [NC-1:0]     SDATA = '0;
    logic              rx_done_tick, frame_err;
    logic [NC*FB-1:0]  b_reg;
    logic [NC*DB-1:0]  data_Out;
    logic [15:0]       frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 SCLK = ~SCLK;

    adc_serial_rx_multi #(
        .FRAME_BITS(FB), .DATA_BITS(DB), .LEAD_ZEROS(4), .N_CH(NC), .AVG_LOG2(AL)
    ) dut (
        .SCLK(SCLK), .reset(reset), .CS(CS), .SDATA(SDATA),
        .rx_done_tick(rx_done_tick), .frame_err(frame_err),
        .b_reg(b_reg), .data_Out(data_Out), .frame_cnt(frame_cnt)
    );

    // frame-level reference state
    logic [DB-1:0] m_data [NC];
    logic [FB-1:0] m_breg [NC];
    logic [15:0]   m_cnt;
    logic          m_tick, m_err;
    int            m_navg;
    int            m_sum  [NC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < NC; ch++) begin
            m_data[ch] = '0;
            m_breg[ch] = '0;
            m_sum[ch]  = 0;
        end
        m_cnt  = '0;
        m_navg = 0;
        m_tick = 1'b0;
        m_err  = 1'b0;
    endtask

    // fr holds the first 16 bits sent on each line: channel ch at fr[ch*16 +: 16]
    task automatic model_frame(input logic [31:0] fr, input int nbits);
        logic valid;
        int   f;
        valid = (nbits >= FB);
        for (int ch = 0; ch < NC; ch++) begin
            f = int'(fr[ch*FB +: FB]);
            if (nbits >= FB) m_breg[ch] = FB'(f);
            else             m_breg[ch] = FB'(((int'(m_breg[ch]) << nbits) | (f >> (FB - nbits))) & 'hFFFF);
            if (f >= 'h1000) valid = 1'b0;
        end
        m_tick = 1'b0;
        m_err  = !valid;
        if (valid) begin
            m_cnt = m_cnt + 16'd1;
`ifdef ADC_AVG_EN
            m_navg++;
            for (int ch = 0; ch < NC; ch++) m_sum[ch] += int'(fr[ch*FB +: DB]);
            if (m_navg == (1 << AL)) begin
                for (int ch = 0; ch < NC; ch++) begin
                    m_data[ch] = DB'(m_sum[ch] / (1 << AL));
                    m_sum[ch]  = 0;
                end
                m_navg = 0;
                m_tick = 1'b1;
            end
`else
            for (int ch = 0; ch < NC; ch++) m_data[ch] = fr[ch*FB +: DB];
            m_tick = 1'b1;
`endif
        end
    endtask

    task automatic check_model(input string tag);
        logic [NC*DB-1:0] ed;
        logic [NC*FB-1:0] eb;
        for (int ch = 0; ch < NC; ch++) begin
            ed[ch*DB +: DB] = m_data[ch];
            eb[ch*FB +: FB] = m_breg[ch];
        end
        check({tag, ".done"}, rx_done_tick, m_tick);
        check({tag, ".err"},  frame_err,    m_err);
        check({tag, ".data"}, data_Out,     ed);
        check({tag, ".cnt"},  frame_cnt,    m_cnt);
        check({tag, ".breg"}, b_reg,        eb);
    endtask

    // Called just after a falling edge; returns just after the falling edge where the result is visible.
    task automatic run_frame(input logic [31:0] fr, input int nbits, input string tag);
        logic [31:0] surplus;
        surplus = $urandom;
        for (int k = 0; k < nbits; k++) begin
            if (k > 0) @(negedge SCLK);
            CS = 1'b0;
            for (int ch = 0; ch < NC; ch++)
                SDATA[ch] = (k < FB) ? fr[ch*FB + FB - 1 - k] : surplus[ch*8 + (k % 8)];
            if (k == 1) check({tag, ".tick_clear"}, {rx_done_tick, frame_err}, 2'b00);
        end
        @(negedge SCLK);
        CS    = 1'b1;
        SDATA = NC'($urandom);
        model_frame(fr, nbits);
        @(negedge SCLK);
        check_model(tag);
    endtask

    typedef struct {
        logic [31:0] fr;
        int          nbits;
        logic        tick;
        logic        err;
        logic [23:0] data;
        logic [15:0] cnt;
    } vec_t;

    vec_t        tbl [7];
    logic [31:0] fr;
    int          nb, sel;

    initial begin
`ifdef ADC_AVG_EN
        tbl[0] = '{32'h0800_0100, 16, 1'b0, 1'b0, 24'h000000, 16'd1};
        tbl[1] = '{32'h0800_0101, 16, 1'b0, 1'b0, 24'h000000, 16'd2};
        tbl[2] = '{32'h0800_0FFF,  5, 1'b0, 1'b1, 24'h000000, 16'd2};
        tbl[3] = '{32'h0800_0102, 16, 1'b0, 1'b0, 24'h000000, 16'd3};
        tbl[4] = '{32'h0800_0104, 18, 1'b1, 1'b0, 24'h800101, 16'd4};
        tbl[5] = '{32'h8000_0100, 16, 1'b0, 1'b1, 24'h800101, 16'd4};
        tbl[6] = '{32'h0004_0000, 16, 1'b0, 1'b0, 24'h800101, 16'd5};
`else
        tbl[0] = '{32'h0123_0ABC, 16, 1'b1, 1'b0, 24'h123ABC, 16'd1};
        tbl[1] = '{32'h0FFF_0FFF, 10, 1'b0, 1'b1, 24'h123ABC, 16'd1};
        tbl[2] = '{32'h8FFF_0111, 16, 1'b0, 1'b1, 24'h123ABC, 16'd1};
        tbl[3] = '{32'h0555_0555, 20, 1'b1, 1'b0, 24'h555555, 16'd2};
        tbl[4] = '{32'h0000_0FFF, 16, 1'b1, 1'b0, 24'h000FFF, 16'd3};
        tbl[5] = '{32'h0000_1000, 16, 1'b0, 1'b1, 24'h000FFF, 16'd3};
        tbl[6] = '{32'h0FFF_0000, 17, 1'b1, 1'b0, 24'hFFF000, 16'd4};
`endif
        model_reset();
        repeat (3) @(negedge SCLK);
        check("rst.done",  rx_done_tick, 1'b0);
        check("rst.err",   frame_err,    1'b0);
        check("rst.data",  data_Out,     '0);
        check("rst.cnt",   frame_cnt,    '0);
        check("rst.breg",  b_reg,        '0);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_frame(tbl[i].fr, tbl[i].nbits, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d.vec_done", i), rx_done_tick, tbl[i].tick);
            check($sformatf("tbl%0d.vec_err", i),  frame_err,    tbl[i].err);
            check($sformatf("tbl%0d.vec_data", i), data_Out,     tbl[i].data);
            check($sformatf("tbl%0d.vec_cnt", i),  frame_cnt,    tbl[i].cnt);
        end

        // sixteen back-to-back frames, CS high for a single edge between them
        for (int i = 0; i < 16; i++)
            run_frame($urandom & 32'h0FFF_0FFF, 16, $sformatf("b2b%0d", i));

        // frame counter wrap
        force dut.frame_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        m_cnt = 16'hFFFF;
        for (int i = 0; i < (1 << AL); i++)
            run_frame($urandom & 32'h0FFF_0FFF, 16, $sformatf("wrap%0d", i));

        // reset in the middle of a frame
        fr = 32'h0FFF_0FFF;
        for (int k = 0; k < 8; k++) begin
            CS    = 1'b0;
            SDATA = {fr[FB*2 - 1 - k], fr[FB - 1 - k]};
            @(negedge SCLK);
        end
        reset = 1'b0;
        CS    = 1'b1;
        @(negedge SCLK);
        model_reset();
        check_model("midrst");
        reset = 1'b1;
        @(negedge SCLK);
        for (int i = 0; i < (1 << AL); i++)
            run_frame(32'h0321_0654 + 32'(i), 16, $sformatf("postrst%0d", i));

        // random frames: lead-bit violations, short and over-long frames, random gaps
        for (int i = 0; i < 60; i++) begin
            fr  = $urandom;
            sel = $urandom_range(0, 4);
            if (sel != 0) fr = fr & 32'h0FFF_0FFF;
            nb  = (sel == 1) ? $urandom_range(1, 15) : $urandom_range(16, 20);
            run_frame(fr, nb, $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 2)) @(negedge SCLK);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
